// File: rtl/bloom_seq_ctrl.sv
// bloom_seq_ctrl: multi-cycle sequencer between the core's custom-instruction port and the Bloom filter.
// Latency: insert n+1, check k*(LOOKUP_LAT+1)+1, clear CLR_WORDS+1, NOP 1 cycle from accept to rsp_valid.
// Backpressure: one op in flight (req_ready only in IDLE); the response is held until rsp_ready.
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_op, req_rs1 (key, LSB byte first), req_len
//   rsp_valid/rsp_ready           response handshake; rsp_result is held while rsp_valid is high
//   busy                          high whenever the sequencer is not idle
//   bf_insert/bf_check/bf_clear   registered, mutually exclusive filter strobes
//   bf_data, bf_clr_addr          key byte for insert/check, word index for clear (0 when unused)
//   bf_match                      filter lookup result, valid LOOKUP_LAT cycles after a bf_check pulse
// Optional: defining BLOOM_CTRL_PERF_EN adds perf_insert_cnt, perf_check_cnt and perf_hit_cnt.
module bloom_seq_ctrl #(
  parameter int CLR_WORDS  = 16,
  parameter int LOOKUP_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [4:0]                   req_op,
  input  logic [31:0]                  req_rs1,
  input  logic [2:0]                   req_len,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_result,
  output logic                         busy,
  output logic                         bf_insert,
  output logic                         bf_check,
  output logic                         bf_clear,
  output logic [7:0]                   bf_data,
  output logic [$clog2(CLR_WORDS)-1:0] bf_clr_addr,
  input  logic                         bf_match
`ifdef BLOOM_CTRL_PERF_EN
  ,
  output logic [31:0]                  perf_insert_cnt,
  output logic [31:0]                  perf_check_cnt,
  output logic [31:0]                  perf_hit_cnt
`endif
);

  localparam int AW = $clog2(CLR_WORDS);
  localparam int WW = $clog2(LOOKUP_LAT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CLR_WORDS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LOOKUP_LAT);

  localparam logic [4:0] OP_INSERT = 5'b00001;
  localparam logic [4:0] OP_CLEAR  = 5'b00011;
  localparam logic [4:0] OP_CHECK  = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSERT,
    S_CHECK_ISSUE,
    S_CHECK_WAIT,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t        state;
  logic [31:0]   rs1_q;
  logic [1:0]    idx;       // byte currently on bf_data / being looked up
  logic [1:0]    last_idx;  // effective length minus one
  logic [WW-1:0] wait_cnt;  // cycles since the current bf_check pulse

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Length 0 is treated as one byte, anything above 4 saturates at the full word.
  function automatic logic [1:0] len_to_last(input logic [2:0] len);
    logic [1:0] l;
    if (len == 3'd0)      l = 2'd0;
    else if (len > 3'd4)  l = 2'd3;
    else                  l = 2'(len - 3'd1);
    return l;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      bf_insert   <= 1'b0;
      bf_check    <= 1'b0;
      bf_clear    <= 1'b0;
      bf_data     <= '0;
      bf_clr_addr <= '0;
      rs1_q       <= '0;
      idx         <= '0;
      last_idx    <= '0;
      wait_cnt    <= '0;
`ifdef BLOOM_CTRL_PERF_EN
      perf_insert_cnt <= '0;
      perf_check_cnt  <= '0;
      perf_hit_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rs1_q     <= req_rs1;
            last_idx  <= len_to_last(req_len);
            idx       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            case (req_op)
              OP_INSERT: begin
                state     <= S_INSERT;
                bf_insert <= 1'b1;
                bf_data   <= req_rs1[7:0];
              end
              OP_CHECK: begin
                state    <= S_CHECK_ISSUE;
                bf_check <= 1'b1;
                bf_data  <= req_rs1[7:0];
              end
              OP_CLEAR: begin
                state       <= S_CLEAR;
                bf_clear    <= 1'b1;
                bf_clr_addr <= '0;
              end
              default: begin
                state      <= S_RESP;
                rsp_valid  <= 1'b1;
                rsp_result <= '0;
              end
            endcase
          end
        end

        S_INSERT: begin
          if (idx == last_idx) begin
            state      <= S_RESP;
            bf_insert  <= 1'b0;
            bf_data    <= '0;
            rsp_valid  <= 1'b1;
            rsp_result <= {30'b0, last_idx} + 32'd1;
`ifdef BLOOM_CTRL_PERF_EN
            perf_insert_cnt <= perf_insert_cnt + 32'd1;
`endif
          end else begin
            idx     <= idx + 2'd1;
            bf_data <= byte_sel(rs1_q, idx + 2'd1);
          end
        end

        S_CHECK_ISSUE: begin
          // The pulse is exactly one cycle; the lookup result is awaited in CHECK_WAIT.
          state    <= S_CHECK_WAIT;
          bf_check <= 1'b0;
          bf_data  <= '0;
          wait_cnt <= WW'(1);
        end

        S_CHECK_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            if (!bf_match) begin
              // A single missing byte proves the key absent; skip the rest.
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
`ifdef BLOOM_CTRL_PERF_EN
              perf_check_cnt <= perf_check_cnt + 32'd1;
`endif
            end else if (idx == last_idx) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= 32'd1;
`ifdef BLOOM_CTRL_PERF_EN
              perf_check_cnt <= perf_check_cnt + 32'd1;
              perf_hit_cnt   <= perf_hit_cnt + 32'd1;
`endif
            end else begin
              state    <= S_CHECK_ISSUE;
              idx      <= idx + 2'd1;
              bf_check <= 1'b1;
              bf_data  <= byte_sel(rs1_q, idx + 2'd1);
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_CLEAR: begin
          if (bf_clr_addr == LAST_ADDR) begin
            state       <= S_RESP;
            bf_clear    <= 1'b0;
            bf_clr_addr <= '0;
            rsp_valid   <= 1'b1;
            rsp_result  <= '0;
          end else begin
            bf_clr_addr <= bf_clr_addr + AW'(1);
          end
        end

        S_RESP: begin
          // Returning to IDLE first means no request is taken in the handshake cycle.
          if (rsp_ready) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bloom_seq_ctrl.md
# bloom_seq_ctrl

Multi-cycle sequencer between the Ibex EX-stage custom-instruction interface and the Bloom filter datapath. Accepts one custom op at a time (insert, check, clear, other) over a valid/ready handshake, then drives the filter's insert/check/clear strobes byte by byte or word by word. Returns a 32-bit result to the core over a held valid/ready response channel. Replaces single-cycle strobing so that multi-byte keys, filter lookup latency and full-array clear are handled in hardware.

## Interface
- CLR_WORDS, 16, filter words swept by a clear; ≥2
- LOOKUP_LAT, 2, cycles from bf_check pulse to valid bf_match; ≥1
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  op presented by EX stage
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  5  5'b00001 insert, 5'b00011 clear, 5'b00100 check, others NOP
- req_rs1  in  32  key bytes, LSB byte first
- req_len  in  3  bytes to process; 0→1, >4→4
- rsp_valid  out  1  result valid, held until accepted
- rsp_ready  in  1  core accepts result
- rsp_result  out  32  op result
- busy  out  1  high in any state other than IDLE
- bf_insert  out  1  filter insert strobe
- bf_check  out  1  filter check strobe, single-cycle pulse
- bf_clear  out  1  filter clear strobe
- bf_data  out  8  key byte for insert/check
- bf_clr_addr  out  $clog2(CLR_WORDS)  word being cleared
- bf_match  in  1  filter lookup result, valid LOOKUP_LAT cycles after bf_check

## Operation
- States: IDLE, INSERT, CHECK_ISSUE, CHECK_WAIT, CLEAR, RESP.
- IDLE: on req_valid & req_ready, latch op, rs1 and effective length n (1..4), clear byte index.
  - Go to INSERT, CHECK_ISSUE or CLEAR by op; NOP goes to RESP.
- INSERT: bf_insert=1, bf_data=rs1 byte[idx]; idx++ each cycle. After n cycles → RESP, result=n (zero-extended).
- CHECK_ISSUE: one cycle with bf_check=1, bf_data=byte[idx] → CHECK_WAIT with wait counter.
- CHECK_WAIT: sample bf_match exactly LOOKUP_LAT cycles after the pulse.
  - Miss → RESP, result=0 (early exit).
  - Hit and idx==n-1 → RESP, result=1.
  - Otherwise idx++ → CHECK_ISSUE.
- CLEAR: bf_clear=1, bf_clr_addr counts 0..CLR_WORDS-1, one word per cycle. After the last word → RESP, result=0.
- NOP result=0.
- RESP: rsp_valid=1, rsp_result stable. On rsp_ready → IDLE next cycle. No new request is accepted in the same cycle.
- Strobes (bf_insert, bf_check, bf_clear) are registered and mutually exclusive; all are 0 outside their states.
- bf_data=0 and bf_clr_addr=0 when unused.
- Request inputs are ignored unless req_ready is high.

## Timing
- Reset values: req_ready=1 (after reset cycle), rsp_valid=0, rsp_result=0, busy=0, all bf_* = 0, state IDLE.
- Accept at cycle 0. Response latencies:
  - Insert: bf_insert cycles 1..n; rsp_valid from cycle n+1.
  - Check, k bytes examined: pulses at cycles 1+j·(LOOKUP_LAT+1); rsp_valid from cycle k·(LOOKUP_LAT+1)+1.
  - Clear: bf_clear cycles 1..CLR_WORDS; rsp_valid from cycle CLR_WORDS+1.
  - NOP: rsp_valid from cycle 1.
- rsp_ready held high: rsp_valid lasts exactly one cycle; req_ready returns the following cycle.
- rst asserted mid-operation: at the next edge all outputs take reset values and the sequence is abandoned. Filter contents are not cleared by rst; software issues clear.
- Counters wrap only at their terminal values defined above; no other wrap-around.

## Configuration
- BLOOM_CTRL_PERF_EN defined: adds outputs perf_insert_cnt, perf_check_cnt, perf_hit_cnt (32 bits each).
  - Incremented once per completed insert, check, and check returning 1.
  - Wrap at 2^32; reset to 0 by rst only.
- BLOOM_CTRL_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles → req_ready=1, busy=0, rsp_valid=0, all bf_* = 0.
- Insert, rs1=0xA1B2C3D4, len=3, rsp_ready=1 → bf_insert cycles 1–3 with bf_data 0xD4, 0xC3, 0xB2; rsp_valid cycle 4, result=3.
- Check, LOOKUP_LAT=2, len=4, model returns hit,hit,miss → three bf_check pulses at cycles 1, 4, 7; rsp_valid cycle 10, result=0.
- Check, len=0, model hit → one pulse; result=1 at cycle 4.
- Clear, CLR_WORDS=16, rsp_ready low for 3 cycles → bf_clr_addr 0..15 on cycles 1–16; rsp_valid held cycles 17–20; req_ready at cycle 21.
- rst pulsed at cycle 5 of a clear → cycle 6: bf_clear=0, state IDLE; op 5'b11111 then completes as NOP with result=0 at latency 1.
